// File: rtl/regbank_dump_ctrl_if.sv
// regbank_dump_ctrl_if: debug-unit handshake and register bank read-override bus of regbank_dump_ctrl
interface regbank_dump_ctrl_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_REGISTER = 5
);
  logic                   dump_req;
  logic                   abort;
  logic                   dump_ready;
  logic [NB_DATA-1:0]     read_data;
  logic [NB_DATA-1:0]     pc;
  logic                   pipeline_stall;
  logic                   write_block;
  logic                   read_override;
  logic [NB_REGISTER-1:0] read_reg_sel;
  logic [NB_DATA-1:0]     dump_data;
  logic                   dump_valid;
  logic                   dump_last;
  logic                   dump_done;
  logic                   busy;
  modport master (
    input  dump_req, abort, dump_ready, read_data, pc,
    output pipeline_stall, write_block, read_override, read_reg_sel,
           dump_data, dump_valid, dump_last, dump_done, busy
  );
  modport slave (
    output dump_req, abort, dump_ready, read_data, pc,
    input  pipeline_stall, write_block, read_override, read_reg_sel,
           dump_data, dump_valid, dump_last, dump_done, busy
  );
endinterface

// File: rtl/regbank_dump_ctrl.sv
// regbank_dump_ctrl: freezes the pipeline and streams R0..R(N_REGISTERS-1) to the debug unit.
// Define REGDUMP_PC_APPEND_EN to append the current PC as a final extra word.
module regbank_dump_ctrl #(
  parameter int NB_DATA      = 32,
  parameter int NB_REGISTER  = 5,
  parameter int N_REGISTERS  = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input logic i_clock,
  input logic i_reset,
  regbank_dump_ctrl_if.master bus
);
  localparam int NB_CNT = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, DRAIN, ADDR, LATCH, SEND, DONE, PCLAT} state_t;
  state_t                 state, state_nxt;
  logic [NB_REGISTER-1:0] index, index_nxt;
  logic [NB_CNT-1:0]      cnt, cnt_nxt;
  logic [NB_DATA-1:0]     data, data_nxt;
  logic                   pc_word, pc_word_nxt;
  logic                   last_reg, reg_phase;
  assign last_reg  = index == NB_REGISTER'(N_REGISTERS - 1);
  assign reg_phase = state inside {ADDR, LATCH, SEND};
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state   <= IDLE;
      index   <= '0;
      cnt     <= '0;
      data    <= '0;
      pc_word <= 1'b0;
    end else begin
      state   <= state_nxt;
      index   <= index_nxt;
      cnt     <= cnt_nxt;
      data    <= data_nxt;
      pc_word <= pc_word_nxt;
    end
  always_comb begin
    state_nxt   = state;
    index_nxt   = index;
    cnt_nxt     = cnt;
    data_nxt    = data;
    pc_word_nxt = pc_word;
    case (state)
      IDLE: if (bus.dump_req) begin
        state_nxt   = DRAIN;
        cnt_nxt     = '0;
        index_nxt   = '0;
        pc_word_nxt = 1'b0;
      end
      DRAIN: if (cnt == NB_CNT'(DRAIN_CYCLES)) begin
        state_nxt = ADDR;
        index_nxt = '0;
      end else cnt_nxt = cnt + 1'b1;
      ADDR:  state_nxt = LATCH;
      LATCH: begin
        state_nxt = SEND;
        data_nxt  = bus.read_data;
      end
      PCLAT: begin
        state_nxt   = SEND;
        data_nxt    = bus.pc;
        pc_word_nxt = 1'b1;
      end
      SEND: if (bus.dump_ready) begin
`ifdef REGDUMP_PC_APPEND_EN
        state_nxt = pc_word ? DONE : last_reg ? PCLAT : ADDR;
`else
        state_nxt = last_reg ? DONE : ADDR;
`endif
        index_nxt = state_nxt == ADDR ? index + 1'b1 : index;
      end
      default: state_nxt = IDLE;
    endcase
    // abort beats a simultaneous handshake and must not disturb the held word
    if (bus.abort && state != IDLE && state != DONE) begin
      state_nxt = IDLE;
      index_nxt = index;
      data_nxt  = data;
    end
  end
  assign bus.busy           = state != IDLE;
  assign bus.pipeline_stall = state inside {DRAIN, ADDR, LATCH, PCLAT, SEND};
  assign bus.write_block    = state inside {ADDR, LATCH, PCLAT, SEND};
  assign bus.read_override  = reg_phase && !pc_word;
  assign bus.read_reg_sel   = reg_phase ? index : '0;
  assign bus.dump_data      = data;
  assign bus.dump_valid     = state == SEND;
`ifdef REGDUMP_PC_APPEND_EN
  assign bus.dump_last      = state == SEND && pc_word;
`else
  assign bus.dump_last      = state == SEND && last_reg;
`endif
  assign bus.dump_done      = state == DONE;
endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// tb_regbank_dump_ctrl: table-driven and randomized dumps checked against a word-list model of the bank.
module tb_regbank_dump_ctrl;
  localparam int N     = 32;
  localparam int DRAIN = 3;
`ifdef REGDUMP_PC_APPEND_EN
  localparam int TOTAL = N + 1;
`else
  localparam int TOTAL = N;
`endif
  typedef struct {
    int rdy_per;
    int abort_at;
    bit req_mid;
    bit abort_req;
    int exp_words;
    int exp_done;
  } vec_t;
  logic i_clock = 1'b0;
  logic i_reset;
  logic [31:0] bank [N];
  logic [4:0] pipe_sel = 5'd7;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [6];
  regbank_dump_ctrl_if #(.NB_DATA(32), .NB_REGISTER(5)) bus ();
  regbank_dump_ctrl #(.NB_DATA(32), .NB_REGISTER(5), .N_REGISTERS(N), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .bus(bus)
  );
  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) bus.read_data <= bank[bus.read_override ? bus.read_reg_sel : pipe_sel];
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] exp_word(input int k);
    return k < N ? bank[k] : bus.pc;
  endfunction
  function automatic logic [63:0] outs();
    return {20'd0, bus.pipeline_stall, bus.write_block, bus.read_override, bus.read_reg_sel,
            bus.dump_data, bus.dump_valid, bus.dump_last, bus.dump_done, bus.busy};
  endfunction
  task automatic run_dump(input int rdy_per, input int abort_at, input bit req_mid, input bit abort_req,
                          output int nw, output int nd);
    int cyc;
    bit first_seen, hold, aborted;
    logic [31:0] pd;
    logic [4:0] ps;
    logic pl;
    nw = 0; nd = 0; cyc = 0;
    first_seen = 0; hold = 0; aborted = 0;
    pd = '0; ps = '0; pl = 0;
    bus.dump_req = 1; bus.abort = abort_req; bus.dump_ready = 0;
    step();
    bus.dump_req = 0; bus.abort = 0;
    chk("stall_rise", bus.pipeline_stall, 1);
    chk("wb_drain", bus.write_block, 0);
    while (cyc < 2000) begin
      if (bus.dump_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          chk("first_latency", cyc, DRAIN + 3);
        end
        if (hold) begin
          chk("hold_data", bus.dump_data, pd);
          chk("hold_sel", bus.read_reg_sel, ps);
          chk("hold_last", bus.dump_last, pl);
        end else begin
          chk("data", bus.dump_data, exp_word(nw));
          chk("last", bus.dump_last, nw == TOTAL - 1);
          if (nw < N) chk("sel", bus.read_reg_sel, nw);
        end
        if (nw < N) chk("override", bus.read_override, 1);
        chk("send_stall", {bus.pipeline_stall, bus.write_block}, 2'b11);
        pd = bus.dump_data; ps = bus.read_reg_sel; pl = bus.dump_last;
        bus.dump_ready = (cyc % rdy_per) == 0;
        bus.dump_req = req_mid && nw == 3;
        if (nw == abort_at) begin
          bus.abort = 1; bus.dump_ready = 1; aborted = 1;
        end
        hold = !bus.dump_ready;
        if (bus.dump_ready && !aborted) nw++;
      end else begin
        bus.dump_ready = rdy_per == 1 ? 1'b1 : 1'($urandom_range(0, 1));
        bus.dump_req = 0;
        hold = 0;
      end
      if (bus.dump_done) begin
        nd++;
        chk("done_release", {bus.pipeline_stall, bus.write_block, bus.read_override, bus.dump_valid}, 4'b0);
      end
      if (!bus.busy) break;
      step();
      cyc++;
      if (aborted) begin
        chk("abort_idle", {bus.busy, bus.pipeline_stall, bus.write_block, bus.read_override, bus.dump_done}, 5'b0);
        bus.abort = 0;
        break;
      end
    end
    chk("dump_ends", bus.busy, 0);
    bus.dump_ready = 0; bus.dump_req = 0; bus.abort = 0;
    step();
  endtask
  initial begin
    int nw, nd, ab, rp;
    vecs[0] = '{1, -1, 0, 0, TOTAL, 1};
    vecs[1] = '{4, -1, 0, 0, TOTAL, 1};
    vecs[2] = '{1, 5, 0, 0, 5, 0};
    vecs[3] = '{1, -1, 1, 0, TOTAL, 1};
    vecs[4] = '{1, -1, 0, 1, TOTAL, 1};
    vecs[5] = '{3, 2, 0, 0, 2, 0};
    for (int k = 0; k < N; k++) bank[k] = 32'h100 + k;
    bus.pc = 32'h40; bus.dump_req = 0; bus.abort = 0; bus.dump_ready = 0;
    i_reset = 1;
    step();
    step();
    chk("reset_outs", outs(), 64'd0);
    i_reset = 0;
    step();
    chk("idle_outs", outs(), 64'd0);
    for (int i = 0; i < 6; i++) begin
      run_dump(vecs[i].rdy_per, vecs[i].abort_at, vecs[i].req_mid, vecs[i].abort_req, nw, nd);
      chk("words", nw, vecs[i].exp_words);
      chk("done_count", nd, vecs[i].exp_done);
    end
    bus.dump_req = 1;
    step();
    bus.dump_req = 0;
    step();
    #2 i_reset = 1;
    #1 chk("reset_mid_drain", outs(), 64'd0);
    #1 i_reset = 0;
    step();
    chk("idle_after_drain_reset", bus.busy, 0);
    bus.dump_req = 1;
    step();
    bus.dump_req = 0;
    for (int c = 0; c < 20 && !bus.dump_valid; c++) step();
    chk("reached_send", bus.dump_valid, 1);
    #2 i_reset = 1;
    #1 chk("reset_mid_send", outs(), 64'd0);
    #1 i_reset = 0;
    step();
    chk("idle_after_send_reset", bus.busy, 0);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N; k++) bank[k] = $urandom;
      bus.pc = $urandom;
      rp = $urandom_range(1, 4);
      ab = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, TOTAL - 1)) : -1;
      run_dump(rp, ab, 0, 0, nw, nd);
      chk("rand_words", nw, ab < 0 ? TOTAL : ab);
      chk("rand_done", nd, ab < 0 ? 1 : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
